// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared widths, PC step and fetch FSM encoding for the PC/fetch-control stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pc_fetch_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int OFF_W_DEF  = 13;
    localparam int PC_INC     = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// PC-relative branch target: pc_out + 4 + sext(offset), word-aligned, with misalignment flag.
// Latency: combinational.
// Backpressure: none.
module pc_target_calc
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OFF_W  = OFF_W_DEF
) (
    input  logic [OFF_W-1:0]  offset_in,
    input  logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] target,
    output logic              misaligned
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0] offset_sext;
    logic [ADDR_W-1:0] raw_target;

    assign offset_sext = {{(ADDR_W-OFF_W){offset_in[OFF_W-1]}}, offset_in};
    assign raw_target  = pc_out + PC_STEP + offset_sext;
    assign misaligned  = |raw_target[1:0];
    assign target      = {raw_target[ADDR_W-1:2], 2'b00};

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC holder and fetch controller: req/ready fetches, branch redirect with squash of in-flight fetch.
// Latency: valid_out/pc_out registered at the completing edge; redirect costs one bubble cycle.
// Backpressure: imem_req/imem_addr held until imem_ready; stall only blocks new launches.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                OFF_W    = OFF_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [OFF_W-1:0]  offset_in,
    input  logic              branch_req,
    input  logic              stall,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              valid_out,
    output logic              branch_busy,
    output logic              align_err
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              align_q, align_d;
    logic              squash_q, squash_d;

    logic [ADDR_W-1:0] calc_target;
    logic              calc_misaligned;

    pc_target_calc #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W)
    ) u_target_calc (
        .offset_in  (offset_in),
        .pc_out     (pc_out_q),
        .target     (calc_target),
        .misaligned (calc_misaligned)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            pc_out_q <= RESET_PC;
            target_q <= RESET_PC;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            align_q  <= 1'b0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            pc_out_q <= pc_out_d;
            target_q <= target_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            align_q  <= align_d;
            squash_q <= squash_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        pc_out_d = pc_out_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        squash_d = squash_q;
        // Every branch_req latches a fresh target, so a later request overrides a pending one.
        target_d = branch_req ? calc_target : target_q;
        align_d  = branch_req & calc_misaligned;
        if (branch_req) begin
            busy_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (branch_req) begin
                    state_d = REDIRECT;
                end else if (!stall) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                if (imem_ready) begin
                    if (squash_q || branch_req) begin
                        state_d = REDIRECT;
                    end else begin
                        valid_d  = 1'b1;
                        pc_out_d = addr_q;
                        pc_d     = addr_q + PC_STEP;
                        addr_d   = addr_q + PC_STEP;
                        if (stall) begin
                            state_d = IDLE;
                        end
                    end
                end else if (branch_req) begin
                    squash_d = 1'b1;
                end
            end
            REDIRECT: begin
                if (!branch_req) begin
                    pc_d     = target_q;
                    addr_d   = target_q;
                    busy_d   = 1'b0;
                    squash_d = 1'b0;
                    state_d  = stall ? IDLE : REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = addr_q;
    assign pc_out      = pc_out_q;
    assign valid_out   = valid_q;
    assign branch_busy = busy_q;
    assign align_err   = align_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, reset/wrap sequences, randomized run vs reference model.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] offset_in;
    logic        branch_req;
    logic        stall;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        branch_busy;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    pc_fetch_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .offset_in   (offset_in),
        .branch_req  (branch_req),
        .stall       (stall),
        .imem_ready  (imem_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .pc_out      (pc_out),
        .valid_out   (valid_out),
        .branch_busy (branch_busy),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic [12:0] off;
        logic        st;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pco;
        logic        vld;
        logic        busy;
        logic        aerr;
    } vec_t;

    vec_t tbl [34];

    // Reference model: tracks fetch activity and redirect bubble as plain flags.
    logic        r_fetching, r_bubble, r_kill, r_busy, r_valid, r_align;
    logic [31:0] r_addr, r_pc, r_pc_out, r_tgt;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic br, input logic [12:0] off, input logic st, input logic rdy);
        branch_req = br;
        offset_in  = off;
        stall      = st;
        imem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        branch_req = 1'b0;
        reset_n    = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic model_reset();
        r_fetching = 1'b0; r_bubble = 1'b0; r_kill = 1'b0; r_busy = 1'b0;
        r_valid = 1'b0; r_align = 1'b0;
        r_addr = 32'h0; r_pc = 32'h0; r_pc_out = 32'h0; r_tgt = 32'h0;
    endtask

    task automatic model_step(input logic br, input logic [12:0] off, input logic st, input logic rdy);
        logic [31:0] dest;
        logic        done;
        dest    = r_pc_out + 32'd4 + {{19{off[12]}}, off};
        r_align = br && (dest[1:0] != 2'b00);
        dest[1:0] = 2'b00;
        r_valid = 1'b0;
        done    = r_fetching && rdy;
        if (r_bubble && !br) begin
            r_pc = r_tgt; r_addr = r_tgt; r_busy = 1'b0; r_kill = 1'b0;
            r_bubble = 1'b0; r_fetching = !st;
        end else if (done && (r_kill || br)) begin
            r_fetching = 1'b0; r_bubble = 1'b1;
        end else if (done) begin
            r_valid = 1'b1; r_pc_out = r_addr; r_addr = r_addr + 32'd4;
            r_pc = r_addr; r_fetching = !st;
        end else if (r_fetching && br) begin
            r_kill = 1'b1;
        end else if (!r_fetching && !r_bubble && br) begin
            r_bubble = 1'b1;
        end else if (!r_fetching && !r_bubble && !st) begin
            r_fetching = 1'b1; r_addr = r_pc;
        end
        if (br) begin
            r_tgt = dest; r_busy = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            br    off       st    rdy   | req   addr          pc_out        vld   busy  aerr
        tbl[0]  = '{1'b0, 13'h0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 13'h0000, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 13'h0000, 1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0004, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 13'h0000, 1'b0, 1'b1, 1'b1, 32'h0000_000C, 32'h0000_0008, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 13'h0000, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_000C, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 13'h0000, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_000C, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 13'h00F0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_000C, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 13'h0000, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_000C, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 13'h0000, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0100, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 13'h0010, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_0100, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_0114, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 13'h0000, 1'b0, 1'b1, 1'b1, 32'h0000_0118, 32'h0000_0114, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 13'h00E8, 1'b0, 1'b1, 1'b0, 32'h0000_0118, 32'h0000_0114, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0114, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 13'h0000, 1'b0, 1'b1, 1'b1, 32'h0000_0204, 32'h0000_0200, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 13'h1FF0, 1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'h0000_0200, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 13'h0000, 1'b1, 1'b0, 1'b1, 32'h0000_0204, 32'h0000_0200, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 13'h0000, 1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0000_0200, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_01F4, 32'h0000_0200, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 13'h0000, 1'b1, 1'b1, 1'b0, 32'h0000_01F8, 32'h0000_01F4, 1'b1, 1'b0, 1'b0};
        tbl[23] = '{1'b1, 13'h1F08, 1'b1, 1'b0, 1'b0, 32'h0000_01F8, 32'h0000_01F4, 1'b0, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 13'h0000, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_01F4, 1'b0, 1'b0, 1'b0};
        tbl[25] = '{1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_01F4, 1'b0, 1'b0, 1'b0};
        tbl[26] = '{1'b0, 13'h0000, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0100, 1'b1, 1'b0, 1'b0};
        tbl[27] = '{1'b1, 13'h0002, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_0100, 1'b0, 1'b1, 1'b1};
        tbl[28] = '{1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        tbl[29] = '{1'b0, 13'h0000, 1'b0, 1'b1, 1'b1, 32'h0000_0108, 32'h0000_0104, 1'b1, 1'b0, 1'b0};
        tbl[30] = '{1'b1, 13'h0100, 1'b0, 1'b0, 1'b1, 32'h0000_0108, 32'h0000_0104, 1'b0, 1'b1, 1'b0};
        tbl[31] = '{1'b1, 13'h0200, 1'b0, 1'b0, 1'b1, 32'h0000_0108, 32'h0000_0104, 1'b0, 1'b1, 1'b0};
        tbl[32] = '{1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 32'h0000_0108, 32'h0000_0104, 1'b0, 1'b1, 1'b0};
        tbl[33] = '{1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_0308, 32'h0000_0104, 1'b0, 1'b0, 1'b0};

        reset_n    = 1'b0;
        branch_req = 1'b0;
        offset_in  = 13'h0;
        stall      = 1'b0;
        imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req",   72'(imem_req),    72'(1'b0));
        chk("reset_addr",  72'(imem_addr),   72'(32'h0));
        chk("reset_pcout", 72'(pc_out),      72'(32'h0));
        chk("reset_valid", 72'(valid_out),   72'(1'b0));
        chk("reset_busy",  72'(branch_busy), 72'(1'b0));
        chk("reset_align", 72'(align_err),   72'(1'b0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 34; i++) begin
            step(tbl[i].br, tbl[i].off, tbl[i].st, tbl[i].rdy);
            chk($sformatf("v%0d_req", i),   72'(imem_req),    72'(tbl[i].req));
            chk($sformatf("v%0d_addr", i),  72'(imem_addr),   72'(tbl[i].addr));
            chk($sformatf("v%0d_pcout", i), 72'(pc_out),      72'(tbl[i].pco));
            chk($sformatf("v%0d_valid", i), 72'(valid_out),   72'(tbl[i].vld));
            chk($sformatf("v%0d_busy", i),  72'(branch_busy), 72'(tbl[i].busy));
            chk($sformatf("v%0d_align", i), 72'(align_err),   72'(tbl[i].aerr));
        end

        // Asynchronous reset while a request is outstanding, before any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req",   72'(imem_req),    72'(1'b0));
        chk("arst_addr",  72'(imem_addr),   72'(32'h0));
        chk("arst_pcout", 72'(pc_out),      72'(32'h0));
        chk("arst_busy",  72'(branch_busy), 72'(1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 13'h0, 1'b0, 1'b1);
        chk("arst_first_req",  72'(imem_req),  72'(1'b1));
        chk("arst_first_addr", 72'(imem_addr), 72'(32'h0));
        step(1'b0, 13'h0, 1'b0, 1'b1);
        chk("arst_deliver_valid", 72'(valid_out), 72'(1'b1));
        chk("arst_deliver_pcout", 72'(pc_out),    72'(32'h0));
        chk("arst_next_addr",     72'(imem_addr), 72'(32'h4));

        // Branch from pc_out=0 with offset -8 lands at the top of memory, then wraps.
        pulse_reset();
        step(1'b1, 13'h1FF8, 1'b1, 1'b0);
        chk("wrap_busy", 72'(branch_busy), 72'(1'b1));
        chk("wrap_req0", 72'(imem_req),    72'(1'b0));
        step(1'b0, 13'h0, 1'b0, 1'b0);
        chk("wrap_addr_top", 72'(imem_addr), 72'(32'hFFFF_FFFC));
        chk("wrap_req1",     72'(imem_req),  72'(1'b1));
        step(1'b0, 13'h0, 1'b0, 1'b1);
        chk("wrap_pcout", 72'(pc_out),    72'(32'hFFFF_FFFC));
        chk("wrap_addr0", 72'(imem_addr), 72'(32'h0));
        step(1'b0, 13'h0, 1'b0, 1'b1);
        chk("wrap_pcout0", 72'(pc_out),    72'(32'h0));
        chk("wrap_addr4",  72'(imem_addr), 72'(32'h4));

        pulse_reset();
        model_reset();
        begin
            logic        br, st, rdy, prev_br;
            logic [12:0] off;
            prev_br = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                br  = !prev_br && ($urandom_range(0, 9) == 0);
                off = 13'($urandom);
                st  = ($urandom_range(0, 3) == 0);
                rdy = ($urandom_range(0, 9) < 6);
                prev_br = br;
                step(br, off, st, rdy);
                model_step(br, off, st, rdy);
                chk($sformatf("rand%0d", c),
                    72'({imem_req, imem_addr, pc_out, valid_out, branch_busy, align_err}),
                    72'({r_fetching, r_addr, r_pc_out, r_valid, r_busy, r_align}));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-control stage that consumes the 13-bit left-shifted branch offset produced by the offset shifter.
- Holds the PC and issues instruction-memory fetches over a req/ready handshake.
- Delivers each fetched address with a one-cycle valid pulse.
- Redirects the fetch stream to the PC-relative branch target on request, squashing any in-flight fetch.

Parameters:
ADDR_W, 32, PC/address width
OFF_W, 13, width of shifted branch offset input
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
offset_in  in  OFF_W  shifted branch offset, two's complement, sampled with branch_req
branch_req  in  1  redirect request, single-cycle pulse
stall  in  1  inhibit launching new fetches
imem_ready  in  1  memory accepts/completes current request
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
pc_out  out  ADDR_W  address of last delivered instruction
valid_out  out  1  one-cycle pulse: pc_out updated with a non-squashed fetch
branch_busy  out  1  redirect pending
align_err  out  1  one-cycle pulse: computed target had bits[1:0]!=0

Behaviour:
- Single clock domain. reset_n is asynchronous and active-low; it is sampled only by clk-domain flops.
- Reset (async assert, any state, including mid-handshake) forces:
  - state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - pc_out=RESET_PC, valid_out=0, branch_busy=0, align_err=0.
  - pending target and squash flag cleared.
- Target computation:
  - target = pc_out + 4 + sext(offset_in) to ADDR_W bits, modulo 2^ADDR_W (wrap-around, no overflow flag).
  - If target[1:0]!=0: align_err pulses in the cycle after branch_req, and target[1:0] is forced to 00.
- Handshake rules:
  - Once imem_req rises it stays high, with imem_addr unchanged, until a cycle with imem_ready=1.
  - A transfer completes on a clk edge with imem_req=1 and imem_ready=1.
  - imem_ready while imem_req=0 is ignored.
- States:
  - IDLE (imem_req=0):
    - branch_req -> REDIRECT, latch target, branch_busy=1.
    - else !stall -> REQ with imem_req=1, imem_addr=pc.
    - else stay.
  - REQ (imem_req=1):
    - !imem_ready & branch_req: latch target, set squash, branch_busy=1, stay REQ.
    - imem_ready & (squash | branch_req): response dropped (no valid_out), latch target if branch_req -> REDIRECT.
    - imem_ready & !stall: valid_out=1, pc_out=imem_addr, pc=imem_addr+4; stay REQ with imem_addr=pc+4 (back-to-back, 1 fetch/cycle).
    - imem_ready & stall: deliver as above -> IDLE, imem_req=0.
  - REDIRECT (one bubble cycle, imem_req=0):
    - pc=target; clear branch_busy and squash.
    - -> REQ with imem_addr=target if !stall, else IDLE.
- Boundary cases:
  - A second branch_req while branch_busy=1 overwrites the pending target (last wins), computed from the current pc_out.
  - branch_req in the same cycle as imem_ready squashes that response.
  - stall never drops an outstanding request.
  - pc+4 wraps 0xFFFF_FFFC -> 0x0000_0000.
- valid_out latency: 1 cycle after the completing edge (registered output).

Decomposition:
- Shared package: state encoding localparams (IDLE, REQ, REDIRECT), PC increment constant 4, width constants.
- One sub-module, pc_target_calc: combinational sign-extend + add + alignment check (offset_in, pc_out -> target, misaligned). The FSM and registers stay in pc_fetch_ctrl.

Test Plan:
- Reset then stall=0, imem_ready=1 held -> imem_addr sequence 0x0, 0x4, 0x8; valid_out pulses each cycle; pc_out tracks one cycle behind.
- imem_ready low 3 cycles on addr 0x8 -> imem_req and imem_addr=0x8 held stable for 3 cycles, no valid_out; deliver on 4th cycle.
- pc_out=0x100, branch_req with offset_in=13'h0010 in IDLE -> REDIRECT; next fetch imem_addr=0x114; branch_busy high exactly one cycle.
- pc_out=0x200, offset_in=13'h1FF0 (-16) while request outstanding -> response on ready squashed (no valid_out); next fetch 0x1F4.
- pc_out=0x100, offset_in=13'h0002 -> align_err one-cycle pulse; fetch 0x104.
- reset_n asserted mid-REQ with imem_req=1 -> imem_req=0 immediately (async); after release, first fetch at RESET_PC.
